// File: rtl/sync_serial_tx.sv
// sync_serial_tx: frames words behind a sync code and shifts them out MSB-first
module sync_serial_tx #(
  parameter int         DATA_W    = 8,
  parameter logic [7:0] SYNC_CODE = 8'h5A,
  parameter int         MAX_WORDS = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  output logic              S_OUT,
  output logic              S_VALID,
  output logic              BUSY
);
  localparam int BW = $clog2(DATA_W);
  localparam int WW = $clog2(MAX_WORDS + 1);
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
  state_t            state;
  logic [2:0]        sync_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     word_cnt;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              hs;
  assign DATA_READY = !RESET && (state == IDLE || (state == DATA && bit_cnt == '0));
  assign hs = DATA_VALID && DATA_READY;
  // Outputs are registered from the next state so each bit appears the cycle after its decision edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      S_OUT     <= 1'b1;
      S_VALID   <= 1'b0;
      BUSY      <= 1'b0;
      sync_cnt  <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      hold_reg  <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          hold_reg <= DATA_IN;
          word_cnt <= '0;
          sync_cnt <= 3'd7;
          state    <= SYNC;
          S_OUT    <= SYNC_CODE[7];
          S_VALID  <= 1'b1;
          BUSY     <= 1'b1;
        end
        SYNC: if (sync_cnt != 3'd0) begin
          sync_cnt <= sync_cnt - 3'd1;
          S_OUT    <= SYNC_CODE[sync_cnt - 3'd1];
        end else begin
          shift_reg <= hold_reg;
          bit_cnt   <= BW'(DATA_W - 1);
          state     <= DATA;
          S_OUT     <= hold_reg[DATA_W-1];
        end
        DATA: if (bit_cnt != '0) begin
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          bit_cnt   <= bit_cnt - 1'b1;
          S_OUT     <= shift_reg[DATA_W-2];
        end else if (hs && 32'(word_cnt) + 1 < MAX_WORDS) begin
          word_cnt  <= word_cnt + 1'b1;
          shift_reg <= DATA_IN;
          bit_cnt   <= BW'(DATA_W - 1);
          S_OUT     <= DATA_IN[DATA_W-1];
        end else if (hs) begin
          word_cnt <= '0;
          hold_reg <= DATA_IN;
          sync_cnt <= 3'd7;
          state    <= SYNC;
          S_OUT    <= SYNC_CODE[7];
        end else begin
          state   <= IDLE;
          S_OUT   <= 1'b1;
          S_VALID <= 1'b0;
          BUSY    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sync_serial_tx.sv
// tb_sync_serial_tx: scoreboard bench for two transmitters (MAX_WORDS 16 and 2) sharing one input stream
module tb_sync_serial_tx;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       DATA_VALID = 1'b1;
  logic [7:0] DATA_IN = 8'hFF;
  logic [1:0] rdy, so, sv, bz;
  int total = 0;
  int bad = 0;
  int pend [2] = '{0, 0};
  int fw [2] = '{0, 0};
  int maxw [2] = '{16, 2};
  bit q0 [$];
  bit q1 [$];

  sync_serial_tx dut0 (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .DATA_READY(rdy[0]), .S_OUT(so[0]), .S_VALID(sv[0]), .BUSY(bz[0])
  );
  sync_serial_tx #(.MAX_WORDS(2)) dut1 (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .DATA_READY(rdy[1]), .S_OUT(so[1]), .S_VALID(sv[1]), .BUSY(bz[1])
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input int d, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d: got %b want %b at %0t", n, d, act, req, $time);
    end
  endtask

  function automatic void push_byte(input int d, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (d == 0) q0.push_back(w[i]);
      else q1.push_back(w[i]);
    end
  endfunction

  // Reference: a frame is a list of pending line bits; ready when at most the final bit remains
  task automatic step(input logic r, input logic v, input logic [7:0] w);
    int p;
    RESET = r;
    DATA_VALID = v;
    DATA_IN = w;
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      p = pend[d];
      if (r) begin
        pend[d] = 0;
        fw[d] = 0;
        if (d == 0) q0.delete();
        else q1.delete();
      end else begin
        if (pend[d] > 0) pend[d]--;
        if (v && p <= 1) begin
          if (p == 0 || fw[d] == maxw[d]) begin
            push_byte(d, 8'h5A);
            pend[d] += 8;
            fw[d] = 0;
          end
          push_byte(d, w);
          pend[d] += 8;
          fw[d]++;
        end
      end
    end
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("ready", d, rdy[d], !r && pend[d] <= 1);
      chk("s_valid", d, sv[d], pend[d] > 0);
      chk("busy", d, bz[d], pend[d] > 0);
      if (pend[d] == 0) chk("idle_line", d, so[d], 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: every valid line bit must match the next expected bit
  initial forever begin
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (sv[d] === 1'b1) begin
        bit e;
        total++;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          bad++;
          $display("FAIL unexpected_bit dut%0d: got %b want none at %0t", d, so[d], $time);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (so[d] !== e) begin
            bad++;
            $display("FAIL line_bit dut%0d: got %b want %b at %0t", d, so[d], e, $time);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hC3);
    idle(20);
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    idle(12);
    step(1'b0, 1'b1, 8'hA5);
    idle(17);
    step(1'b0, 1'b1, 8'h3C);
    idle(20);
    step(1'b0, 1'b1, 8'h11);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h33);
    idle(30);
    step(1'b0, 1'b1, 8'h77);
    idle(3);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h96);
    idle(20);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 6, 8'($urandom));
    idle(40);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL leftover_bits: got %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
